// File: rtl/conversor_sinal_bcd_pkg.sv
// Shared types and constants for the signed/unsigned 8-bit to 3-digit BCD converter.
package conversor_sinal_bcd_pkg;

  localparam int LARGURA_DADO = 8;
  localparam int N_DIGITOS    = 3;
  localparam int LARGURA_BCD  = 4 * N_DIGITOS;

  // Index of the last double-dabble iteration (8 shifts, counter 0..7)
  localparam logic [2:0] ULTIMA_ITERACAO = 3'd7;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

endpackage

// File: rtl/conversor_sinal_bcd_ajuste_bcd.sv
// Double-dabble nibble correction: adds 3 to a BCD digit that is 5 or more.
module ajuste_bcd
  import conversor_sinal_bcd_pkg::*;
(
  input  logic [3:0] valor_i,
  output logic [3:0] valor_o
);

  assign valor_o = (valor_i >= 4'd5) ? (valor_i + 4'd3) : valor_i;

endmodule

// File: rtl/conversor_sinal_bcd.sv
// Iterative sign-magnitude BCD converter, one double-dabble step per clock.
// States: OCIOSO = idle, waits for start | CONVERTE = shifting | FIM = pronto pulse.
module conversor_sinal_bcd
  import conversor_sinal_bcd_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LARGURA_DADO-1:0] entrada,
  input  logic                    modo_signed,
  output logic                    sinal,
  output logic [3:0]              centenas,
  output logic [3:0]              dezenas,
  output logic [3:0]              unidades,
  output logic                    ocupado,
  output logic                    pronto
);

  estado_t                 estado_q;
  logic                    negativo_q;
  logic [LARGURA_DADO-1:0] mag_q, mag_d;
  logic [LARGURA_BCD-1:0]  bcd_q, bcd_d, bcd_ajustado;
  logic [2:0]              cnt_q;
  logic                    sinal_q, ocupado_q, pronto_q;
  logic [3:0]              centenas_q, dezenas_q, unidades_q;
  logic                    negativo_entrada;

  for (genvar i = 0; i < N_DIGITOS; i++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .valor_i (bcd_q[4*i +: 4]),
      .valor_o (bcd_ajustado[4*i +: 4])
    );
  end

  // The hundreds digit never exceeds 2, so the bit shifted out is always 0
  always_comb begin
    bcd_d = '0;
    mag_d = '0;
    {bcd_d, mag_d} = {bcd_ajustado, mag_q} << 1;
  end

  assign negativo_entrada = modo_signed & entrada[LARGURA_DADO-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= OCIOSO;
      negativo_q <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      sinal_q    <= 1'b0;
      centenas_q <= '0;
      dezenas_q  <= '0;
      unidades_q <= '0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (start) begin
            negativo_q <= negativo_entrada;
            // -0x80 wraps to 0x80, which is exactly magnitude 128
            mag_q      <= negativo_entrada ? (~entrada + 8'd1) : entrada;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ocupado_q  <= 1'b1;
            estado_q   <= CONVERTE;
          end
        end
        CONVERTE: begin
          bcd_q <= bcd_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == ULTIMA_ITERACAO) begin
            sinal_q    <= negativo_q;
            centenas_q <= bcd_d[11:8];
            dezenas_q  <= bcd_d[7:4];
            unidades_q <= bcd_d[3:0];
            pronto_q   <= 1'b1;
            estado_q   <= FIM;
          end
        end
        FIM: begin
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
          estado_q  <= OCIOSO;
        end
        default: begin
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
          estado_q  <= OCIOSO;
        end
      endcase
    end
  end

  assign sinal    = sinal_q;
  assign centenas = centenas_q;
  assign dezenas  = dezenas_q;
  assign unidades = unidades_q;
  assign ocupado  = ocupado_q;
  assign pronto   = pronto_q;

endmodule

// File: tb/tb_conversor_sinal_bcd.sv
// Directed and randomized checks of conversor_sinal_bcd against a decimal arithmetic model.
module tb_conversor_sinal_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] entrada;
  logic       modo_signed;
  logic       sinal;
  logic [3:0] centenas, dezenas, unidades;
  logic       ocupado, pronto;

  int checks   = 0;
  int failures = 0;

  conversor_sinal_bcd dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .entrada     (entrada),
    .modo_signed (modo_signed),
    .sinal       (sinal),
    .centenas    (centenas),
    .dezenas     (dezenas),
    .unidades    (unidades),
    .ocupado     (ocupado),
    .pronto      (pronto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: interpret the byte as an integer, then split |value| into decimal digits
  task automatic modelo(input logic [7:0] e, input logic m,
                        output logic s, output int c, output int d, output int u);
    int v, mag;
    v   = m ? int'($signed(e)) : int'(e);
    s   = (v < 0);
    mag = (v < 0) ? -v : v;
    c   = mag / 100;
    d   = (mag / 10) % 10;
    u   = mag % 10;
  endtask

  task automatic chk_saida(input string tag, input logic s, input int c, input int d, input int u);
    chk({tag, "_sinal"}, {31'd0, sinal}, {31'd0, s});
    chk({tag, "_cent"}, {28'd0, centenas}, c);
    chk({tag, "_dez"}, {28'd0, dezenas}, d);
    chk({tag, "_unid"}, {28'd0, unidades}, u);
  endtask

  task automatic converte(input logic [7:0] e, input logic m, input string tag);
    logic es;
    int   ec, ed, eu, ciclos;
    bit   achou;
    modelo(e, m, es, ec, ed, eu);
    @(negedge clk);
    start = 1'b1; entrada = e; modo_signed = m;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; entrada = 8'($urandom); modo_signed = 1'($urandom);
    chk({tag, "_ocupado_E0"}, {31'd0, ocupado}, 1);
    ciclos = 0; achou = 0;
    while (!achou && ciclos < 20) begin
      @(posedge clk);
      ciclos++;
      @(negedge clk);
      if (pronto) achou = 1;
    end
    chk({tag, "_latencia"}, ciclos, 8);
    chk_saida(tag, es, ec, ed, eu);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pronto_E9"}, {31'd0, pronto}, 0);
    chk({tag, "_ocupado_E9"}, {31'd0, ocupado}, 0);
    chk_saida({tag, "_hold"}, es, ec, ed, eu);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n_pronto, k_pronto, ocup8, ocup9, cap_c, cap_d, cap_u;
    logic cap_s;
    rst = 1'b1; start = 1'b0; entrada = 8'h00; modo_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sinal", {31'd0, sinal}, 0);
    chk("reset_digitos", {20'd0, centenas, dezenas, unidades}, 0);
    chk("reset_ocupado", {31'd0, ocupado}, 0);
    chk("reset_pronto", {31'd0, pronto}, 0);
    rst = 1'b0;

    converte(8'hFF, 1'b0, "u255");
    converte(8'h80, 1'b1, "s_min");
    converte(8'hFF, 1'b1, "s_m1");
    converte(8'h00, 1'b1, "s_zero");
    converte(8'h80, 1'b0, "u128");
    converte(8'h7F, 1'b1, "s_127");
    converte(8'h01, 1'b0, "u1");

    // Busy rejection: second start at E3 must be ignored
    @(negedge clk);
    start = 1'b1; entrada = 8'h64; modo_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; entrada = 8'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; entrada = 8'h09; modo_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk_saida("busy_hold", 1'b0, 0, 0, 1);
    n_pronto = 0; k_pronto = 0; ocup8 = 0; ocup9 = 1;
    cap_s = 1'bx; cap_c = -1; cap_d = -1; cap_u = -1;
    for (int k = 4; k <= 24; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pronto) begin
        n_pronto++;
        if (n_pronto == 1) begin
          k_pronto = k; cap_s = sinal; cap_c = centenas; cap_d = dezenas; cap_u = unidades;
        end
      end
      if (k == 8) ocup8 = ocupado;
      if (k == 9) ocup9 = ocupado;
    end
    chk("busy_n_pronto", n_pronto, 1);
    chk("busy_latencia", k_pronto, 8);
    chk("busy_sinal", {31'd0, cap_s}, 0);
    chk("busy_cent", cap_c, 1);
    chk("busy_dez", cap_d, 0);
    chk("busy_unid", cap_u, 0);
    chk("busy_ocupado_E8", ocup8, 1);
    chk("busy_ocupado_E9", ocup9, 0);

    // Reset mid-conversion
    @(negedge clk);
    start = 1'b1; entrada = 8'hC8; modo_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_sinal", {31'd0, sinal}, 0);
    chk("rst_mid_digitos", {20'd0, centenas, dezenas, unidades}, 0);
    chk("rst_mid_ocupado", {31'd0, ocupado}, 0);
    chk("rst_mid_pronto", {31'd0, pronto}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_pronto = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pronto || ocupado) n_pronto++;
    end
    chk("rst_mid_sem_pronto", n_pronto, 0);
    converte(8'h2A, 1'b0, "pos_rst_42");

    for (int i = 0; i < 24; i++) begin
      converte(8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
